// File: rtl/wb_stage_pipe.sv
`default_nettype none
// ============================================================================
// wb_stage_pipe : MEM->WB pipeline register with two-entry skid buffer,
//                 valid/ready flow control, flush, and a forwarding tap.
// Revision 1.0
// ============================================================================
module wb_stage_pipe #(
  parameter int DATA_W    = 64,
  parameter int RD_W      = 5,
  parameter int CTRL_W    = 10,
  parameter int REGWR_BIT = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [RD_W-1:0]   in_rd,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [RD_W-1:0]   out_rd,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic              fwd_valid,
  output logic [RD_W-1:0]   fwd_rd,
  output logic [DATA_W-1:0] fwd_data,
  output logic [1:0]        occ
);

  // State encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic [RD_W-1:0]   rd;
    logic [DATA_W-1:0] data;
  } entry_t;

  state_e state_q, state_d;
  entry_t main_q, main_d;
  entry_t skid_q, skid_d;
  entry_t in_entry;
  logic   accept;
  logic   consume;

  assign in_entry  = '{ctrl: in_ctrl, rd: in_rd, data: in_data};
  assign in_ready  = (state_q != TWO);
  assign out_valid = (state_q != EMPTY);
  assign accept    = in_valid & in_ready;
  assign consume   = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      // Anything accepted this cycle is dropped; a consumed head is already delivered.
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d = ONE;
            main_d  = in_entry;
          end
        end
        ONE: begin
          if (accept && consume) begin
            main_d = in_entry;
          end else if (accept) begin
            state_d = TWO;
            skid_d  = in_entry;
          end else if (consume) begin
            state_d = EMPTY;
          end
        end
        TWO: begin
          if (consume) begin
            state_d = ONE;
            main_d  = skid_q;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  // Control is gated so an empty stage can never request a register write.
  assign out_data  = main_q.data;
  assign out_rd    = main_q.rd;
  assign out_ctrl  = out_valid ? main_q.ctrl : '0;
  assign fwd_valid = out_valid & main_q.ctrl[REGWR_BIT];
  assign fwd_rd    = main_q.rd;
  assign fwd_data  = main_q.data;
  assign occ       = state_q;

endmodule
`default_nettype wire

// File: tb/tb_wb_stage_pipe.sv
`default_nettype none
// ============================================================================
// tb_wb_stage_pipe : scoreboard bench for wb_stage_pipe with directed vectors.
// Revision 1.0
// ============================================================================
module tb_wb_stage_pipe;

  localparam int DATA_W = 64;
  localparam int RD_W   = 5;
  localparam int CTRL_W = 10;

  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic [RD_W-1:0]   rd;
    logic [DATA_W-1:0] data;
  } beat_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              flush = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] in_data = '0;
  logic [RD_W-1:0]   in_rd = '0;
  logic [CTRL_W-1:0] in_ctrl = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [DATA_W-1:0] out_data;
  logic [RD_W-1:0]   out_rd;
  logic [CTRL_W-1:0] out_ctrl;
  logic              fwd_valid;
  logic [RD_W-1:0]   fwd_rd;
  logic [DATA_W-1:0] fwd_data;
  logic [1:0]        occ;

  int    total = 0;
  int    bad   = 0;
  beat_t exp_q[$];

  wb_stage_pipe #(
    .DATA_W(DATA_W), .RD_W(RD_W), .CTRL_W(CTRL_W), .REGWR_BIT(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_rd(in_rd), .in_ctrl(in_ctrl),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_rd(out_rd), .out_ctrl(out_ctrl),
    .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
    .occ(occ)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pops and compares on every consume; flush discards held beats.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_beat: got data 0x%0h, none expected", out_data);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          chk("sb_data", out_data, e.data);
          chk("sb_rd", 64'(out_rd), 64'(e.rd));
          chk("sb_ctrl", 64'(out_ctrl), 64'(e.ctrl));
          chk("sb_fwd_data", fwd_data, e.data);
        end
      end
      if (flush) exp_q.delete();
    end
  end

  // Call just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [DATA_W-1:0] d, input logic [RD_W-1:0] rd,
                      input logic [CTRL_W-1:0] ctrl);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_rd    = rd;
    in_ctrl  = ctrl;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      total++;
      bad++;
      $display("FAIL send_timeout: in_ready stuck low for data 0x%0h", d);
    end else if (!flush) begin
      exp_q.push_back('{ctrl: ctrl, rd: rd, data: d});
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset held with an incoming beat offered
    in_valid = 1'b1;
    in_data  = 64'hAA;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_ctrl", 64'(out_ctrl), 64'd0);
    chk("rst_occ", 64'(occ), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_data", out_data, 64'd0);
    chk("rst_fwd_valid", 64'(fwd_valid), 64'd0);
    step();
    in_valid = 1'b0;
    rst_n    = 1'b1;
    step();

    // First beat after reset, held so forwarding can be observed
    send(64'h11, 5'd3, 10'h100);
    chk("first_data", out_data, 64'h11);
    chk("first_rd", 64'(out_rd), 64'd3);
    chk("first_fwd_valid", 64'(fwd_valid), 64'd1);
    chk("first_fwd_rd", 64'(fwd_rd), 64'd3);
    out_ready = 1'b1;
    step();
    chk("first_drained", 64'(occ), 64'd0);

    // Streaming at full rate
    for (int i = 1; i <= 8; i++) begin
      send(64'(i), 5'(i), 10'h000);
      chk("stream_occ", 64'(occ), 64'd1);
      chk("stream_in_ready", 64'(in_ready), 64'd1);
    end
    step();
    chk("stream_empty", 64'(occ), 64'd0);

    // Skid fill under backpressure
    out_ready = 1'b0;
    send(64'h5, 5'd1, 10'h101);
    send(64'h6, 5'd2, 10'h102);
    chk("skid_occ", 64'(occ), 64'd2);
    chk("skid_in_ready", 64'(in_ready), 64'd0);
    chk("skid_head", out_data, 64'h5);
    step();
    chk("skid_hold", out_data, 64'h5);
    out_ready = 1'b1;
    step();
    chk("skid_after_pop", out_data, 64'h6);
    chk("skid_occ1", 64'(occ), 64'd1);
    step();
    chk("skid_drained", 64'(occ), 64'd0);

    // Flush with two beats held and a beat offered
    out_ready = 1'b0;
    send(64'h21, 5'd4, 10'h100);
    send(64'h22, 5'd5, 10'h100);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_data  = 64'h9;
    in_rd    = 5'd9;
    in_ctrl  = 10'h100;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("flush_occ", 64'(occ), 64'd0);
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    chk("flush_out_ctrl", 64'(out_ctrl), 64'd0);
    chk("flush_fwd_valid", 64'(fwd_valid), 64'd0);
    out_ready = 1'b1;
    repeat (3) step();

    // Bubble gating of control after the head is consumed
    send(64'h33, 5'd6, 10'h3FF);
    chk("bubble_ctrl_live", 64'(out_ctrl), 64'h3FF);
    step();
    chk("bubble_ctrl_zero", 64'(out_ctrl), 64'd0);
    chk("bubble_fwd_valid", 64'(fwd_valid), 64'd0);
    chk("bubble_out_valid", 64'(out_valid), 64'd0);

    // Asynchronous reset between edges with both entries held
    out_ready = 1'b0;
    send(64'h41, 5'd7, 10'h100);
    send(64'h42, 5'd8, 10'h100);
    chk("areset_pre_occ", 64'(occ), 64'd2);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("areset_out_valid", 64'(out_valid), 64'd0);
    chk("areset_occ", 64'(occ), 64'd0);
    chk("areset_in_ready", 64'(in_ready), 64'd1);
    chk("areset_out_data", out_data, 64'd0);
    step();
    rst_n = 1'b1;
    step();

    // Traffic after reset recovery
    out_ready = 1'b1;
    send(64'h55, 5'd10, 10'h0FF);
    chk("post_fwd_valid", 64'(fwd_valid), 64'd0);
    repeat (2) step();
    chk("sb_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/wb_stage_pipe.md
# wb_stage_pipe

Parametrised pipeline stage register with a two-entry skid buffer, used between MEM and WB. It carries a data payload, a destination-register index and a control vector, with full valid/ready flow control and a synchronous flush. Control outputs are zeroed whenever no valid beat is held, so the stage cannot issue a spurious write. The stage also exposes its head entry as a forwarding source for hazard logic.

## Interface

**Parameters**
- DATA_W, 64: payload width (result or load data).
- RD_W, 5: destination-register index width.
- CTRL_W, 10: WB control vector width.
- REGWR_BIT, 8: index in the control vector of the register-write enable used for forwarding.

**Ports**
- Clk, input, 1: clock; all state changes on the rising edge.
- Rst_n, input, 1: asynchronous, active-low reset.
- flush, input, 1: synchronous discard of all held and incoming beats.
- in_valid, input, 1: upstream beat present.
- in_ready, output, 1: stage can accept a beat.
- in_data, input, DATA_W: payload.
- in_rd, input, RD_W: destination register.
- in_ctrl, input, CTRL_W: WB control vector.
- out_valid, output, 1: head beat present.
- out_ready, input, 1: downstream consumes the head beat.
- out_data, output, DATA_W: head payload.
- out_rd, output, RD_W: head destination.
- out_ctrl, output, CTRL_W: head control; all-zero when out_valid=0.
- fwd_valid, output, 1: out_valid & out_ctrl[REGWR_BIT].
- fwd_rd, output, RD_W: equals out_rd.
- fwd_data, output, DATA_W: equals out_data.
- occ, output, 2: entries held (0..2).

## Operation

- Storage: a main entry (head) and a skid entry, each holding {ctrl, rd, data}.
- Handshake events:
  - accept = in_valid & in_ready.
  - consume = out_valid & out_ready.
- States: EMPTY (occ=0), ONE (main valid, occ=1), TWO (both valid, occ=2).
- in_ready = (state != TWO). It is a function of state only, never of in_valid or out_ready.
- out_valid = (state != EMPTY). out_data, out_rd and out_ctrl always present the main entry.
- Transitions when flush=0:
  - EMPTY: accept → ONE, main ← in.
  - ONE, accept & consume → ONE, main ← in.
  - ONE, accept & !consume → TWO, skid ← in.
  - ONE, consume & !accept → EMPTY.
  - ONE, neither → hold.
  - TWO, consume → ONE, main ← skid.
  - TWO, no consume → hold (accept cannot occur because in_ready=0).
- flush=1:
  - The next state is EMPTY regardless of accept or consume.
  - A beat accepted in the flush cycle is dropped.
  - A beat consumed in the flush cycle counts as delivered.
- Ordering: beats leave in strict acceptance order, with no loss or duplication.
- Output gating:
  - When state=EMPTY, out_ctrl is forced to 0 and fwd_valid=0.
  - out_data and out_rd may hold stale values while out_valid=0.
- Data stability: while out_valid=1 & out_ready=0, out_data, out_rd and out_ctrl must not change.
- No width arithmetic. Payload fields pass bit-exact.

## Timing

- Reset (Rst_n=0, asynchronous):
  - state=EMPTY, all entry registers 0.
  - out_valid=0, out_ctrl=0, out_data=0, out_rd=0.
  - fwd_valid=0, occ=0, in_ready=1.
- Release of Rst_n takes effect on the first rising Clk edge after deassertion.
- Reset asserted mid-operation drops all held beats immediately; outputs take reset values within the same cycle.
- Latency: a beat accepted at edge N appears at out_* after edge N (1 cycle), provided the stage was EMPTY or ONE-and-consumed.
- Throughput: 1 beat/cycle sustained when out_ready=1 continuously. The skid entry is never used in that case.
- Backpressure:
  - out_ready low for one cycle with in_valid high moves the stage ONE → TWO.
  - in_ready drops on the following cycle, not combinationally.
- All outputs are registered or derived from registered state plus REGWR_BIT gating. There is no combinational path from in_* or out_ready to any output.

## Test plan

- **Reset:** hold Rst_n=0 and drive in_valid=1, in_data=0xAA → out_valid=0, out_ctrl=0, occ=0, in_ready=1. Release; the first accept of in_data=0x11, in_rd=3, in_ctrl=0x100 gives out_data=0x11, out_rd=3 and fwd_valid=1 one cycle later.
- **Streaming:** 8 beats in_data=1..8 back-to-back with out_ready=1 → outputs 1..8 on consecutive cycles, occ never exceeds 1, in_ready stays 1.
- **Skid fill:** beats A=0x5, B=0x6 while out_ready=0 → occ=2 and in_ready=0 after the 2nd edge; out_data holds 0x5. Raise out_ready → 0x5 then 0x6, then occ=0.
- **Flush:** occ=2 and flush=1 with in_valid=1, in_data=0x9 → next cycle occ=0, out_valid=0, out_ctrl=0. Beat 0x9 is never output.
- **Bubble gating:** in_ctrl=0x3FF accepted then consumed with no new beat → the following cycle out_ctrl=0x000 and fwd_valid=0.
- **Async reset mid-stream:** occ=2, assert Rst_n=0 between edges → out_valid=0 and occ=0 immediately, before the next Clk edge.
